// File: rtl/gnr_attractor_ctrl_if.sv
// Request/result bus of the attractor controller: a one-cycle start with its
// initial state, and the busy/done handshake with the detected results.
interface gnr_attractor_ctrl_if #(
  parameter int N_NODES = 8,
  parameter int CW      = 16
);
  logic               start;
  logic [N_NODES-1:0] init_vec;
  logic               busy;
  logic               done;
  logic               timeout;
  logic [CW-1:0]      meet_steps;
  logic [CW-1:0]      period;
  logic [N_NODES-1:0] attractor;

  modport master (
    output start, init_vec,
    input  busy, done, timeout, meet_steps, period, attractor
  );

  modport slave (
    input  start, init_vec,
    output busy, done, timeout, meet_steps, period, attractor
  );
endinterface

// File: rtl/gnr_attractor_ctrl.sv
// Floyd cycle detection over dual-copy gene-network cells, followed by an
// attractor period measurement. Moore outputs only: strobes decode the state.
module gnr_attractor_ctrl #(
  parameter int N_NODES   = 8,
  parameter int CW        = 16,
  parameter int MAX_STEPS = 1000
) (
  input  logic               clk,
  input  logic               rst,
  gnr_attractor_ctrl_if.slave bus,
  input  logic [N_NODES-1:0] s0_vec_i,
  input  logic [N_NODES-1:0] s1_vec_i,
  output logic               reset_nos_o,
  output logic [N_NODES-1:0] init_state_o,
  output logic               start_s0_o,
  output logic               start_s1_o
);

  localparam logic [CW-1:0] MaxSteps = CW'(MAX_STEPS);

  typedef enum logic [2:0] {
    IDLE, LOAD, RSTEP, RCHK, PSTEP, PCHK, DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      k_q, k_d;
  logic [CW-1:0]      p_q, p_d;
  logic [CW-1:0]      meet_q, meet_d;
  logic [CW-1:0]      period_q, period_d;
  logic [N_NODES-1:0] init_q, init_d;
  logic [N_NODES-1:0] attr_q, attr_d;
  logic               timeout_q, timeout_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      k_q       <= '0;
      p_q       <= '0;
      meet_q    <= '0;
      period_q  <= '0;
      init_q    <= '0;
      attr_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      p_q       <= p_d;
      meet_q    <= meet_d;
      period_q  <= period_d;
      init_q    <= init_d;
      attr_q    <= attr_d;
      timeout_q <= timeout_d;
    end
  end

  // NOTE: every signal gets a hold default before the case statement, so no
  // path through the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    p_d       = p_q;
    meet_d    = meet_q;
    period_d  = period_q;
    init_d    = init_q;
    attr_d    = attr_q;
    timeout_d = timeout_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          init_d    = bus.init_vec;
          k_d       = '0;
          p_d       = '0;
          meet_d    = '0;
          period_d  = '0;
          attr_d    = '0;
          timeout_d = 1'b0;
          state_d   = LOAD;
        end
      end
      LOAD:  state_d = RSTEP;
      RSTEP: begin
        k_d     = k_q + CW'(1);
        state_d = RCHK;
      end
      RCHK: begin
        // Odd k leaves the tortoise half a step ahead of k/2, so only even k compares.
        if (!k_q[0] && (s0_vec_i == s1_vec_i)) begin
          meet_d  = k_q;
          attr_d  = s0_vec_i;
          state_d = PSTEP;
        end else if (k_q == MaxSteps) begin
          timeout_d = 1'b1;
          period_d  = '0;
          meet_d    = k_q;
          state_d   = DONE;
        end else begin
          state_d = RSTEP;
        end
      end
      PSTEP: begin
        p_d     = p_q + CW'(1);
        state_d = PCHK;
      end
      PCHK: begin
        if (s1_vec_i == attr_q) begin
          period_d = p_q;
          state_d  = DONE;
        end else if (p_q == MaxSteps) begin
          timeout_d = 1'b1;
          state_d   = DONE;
        end else begin
          state_d = PSTEP;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign reset_nos_o    = (state_q == LOAD);
  assign start_s0_o     = (state_q == RSTEP);
  assign start_s1_o     = (state_q == RSTEP) || (state_q == PSTEP);
  assign init_state_o   = init_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == DONE);
  assign bus.timeout    = timeout_q;
  assign bus.meet_steps = meet_q;
  assign bus.period     = period_q;
  assign bus.attractor  = attr_q;

endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// Bench for gnr_attractor_ctrl: behavioural cell arrays around two controllers
// (long and short step bound) and a trajectory-based Floyd reference.
module tb_gnr_attractor_ctrl;
  localparam int N     = 8;
  localparam int CW    = 16;
  localparam int MAX_L = 1000;
  localparam int MAX_S = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gnr_attractor_ctrl_if #(.N_NODES(N), .CW(CW)) l_if ();
  gnr_attractor_ctrl_if #(.N_NODES(N), .CW(CW)) s_if ();

  logic [N-1:0] l_s0 = '0, l_s1 = '0, l_init;
  logic [N-1:0] s_s0 = '0, s_s1 = '0, s_init;
  logic         l_rn, l_st0, l_st1, s_rn, s_st0, s_st1;
  logic         l_par = 1'b0, s_par = 1'b0;

  gnr_attractor_ctrl #(.N_NODES(N), .CW(CW), .MAX_STEPS(MAX_L)) dut (
    .clk(clk), .rst(rst), .bus(l_if.slave),
    .s0_vec_i(l_s0), .s1_vec_i(l_s1), .reset_nos_o(l_rn),
    .init_state_o(l_init), .start_s0_o(l_st0), .start_s1_o(l_st1)
  );

  gnr_attractor_ctrl #(.N_NODES(N), .CW(CW), .MAX_STEPS(MAX_S)) dut_short (
    .clk(clk), .rst(rst), .bus(s_if.slave),
    .s0_vec_i(s_s0), .s1_vec_i(s_s1), .reset_nos_o(s_rn),
    .init_state_o(s_init), .start_s0_o(s_st0), .start_s1_o(s_st1)
  );

  // Network under test: 0 identity, 1 all-toggle, 2 3-bit incrementer, else random table.
  int           net_sel = 0;
  logic [N-1:0] lut [256];

  function automatic logic [N-1:0] f(input logic [N-1:0] s);
    case (net_sel)
      0:       return s;
      1:       return ~s;
      2:       return {s[7:3], s[2:0] + 3'd1};
      default: return lut[s];
    endcase
  endfunction

  int l_s0_cnt = 0, l_s1_cnt = 0, l_t_cnt = 0, l_done_cnt = 0;
  int s_s0_cnt = 0, s_s1_cnt = 0, s_t_cnt = 0, s_done_cnt = 0;
  int viol = 0;

  always @(posedge clk) begin
    if (l_rn) begin
      l_s0 <= l_init; l_s1 <= l_init; l_par <= 1'b0;
    end else begin
      if (l_st1) l_s1 <= f(l_s1);
      if (l_st0) begin
        if (!l_par) begin l_s0 <= f(l_s0); l_t_cnt <= l_t_cnt + 1; end
        l_par <= ~l_par;
      end
    end
    if (s_rn) begin
      s_s0 <= s_init; s_s1 <= s_init; s_par <= 1'b0;
    end else begin
      if (s_st1) s_s1 <= f(s_s1);
      if (s_st0) begin
        if (!s_par) begin s_s0 <= f(s_s0); s_t_cnt <= s_t_cnt + 1; end
        s_par <= ~s_par;
      end
    end
    if (l_st0) l_s0_cnt <= l_s0_cnt + 1;
    if (l_st1) l_s1_cnt <= l_s1_cnt + 1;
    if (s_st0) s_s0_cnt <= s_s0_cnt + 1;
    if (s_st1) s_s1_cnt <= s_s1_cnt + 1;
    if (l_if.done) l_done_cnt <= l_done_cnt + 1;
    if (s_if.done) s_done_cnt <= s_done_cnt + 1;
    if ((l_rn && (l_st0 || l_st1)) || (l_st0 && !l_st1) ||
        (s_rn && (s_st0 || s_st1)) || (s_st0 && !s_st1))
      viol <= viol + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: walk the trajectory x_i = f^i(init); the meet is the first even k
  // with x_(k/2) == x_k, the period is the first return of f^p to the attractor.
  function automatic void ref_model(input logic [N-1:0] init, input int max,
                                    output int meet, output int per,
                                    output logic [N-1:0] attr, output bit to,
                                    output int n_s1);
    logic [N-1:0] traj [0:MAX_L];
    logic [N-1:0] x;
    traj[0] = init;
    for (int i = 1; i <= max; i++) traj[i] = f(traj[i-1]);
    meet = max; per = 0; attr = '0; to = 1'b1;
    for (int k = 2; k <= max; k += 2) begin
      if (traj[k/2] == traj[k]) begin
        meet = k; attr = traj[k]; to = 1'b0;
        break;
      end
    end
    n_s1 = meet;
    if (!to) begin
      x = attr;
      for (int p = 1; p <= max; p++) begin
        x = f(x);
        if (x == attr) begin per = p; break; end
      end
      if (per == 0) begin to = 1'b1; n_s1 = meet + max; end
      else n_s1 = meet + per;
    end
  endfunction

  function automatic logic cur_done(input bit sh);
    return sh ? s_if.done : l_if.done;
  endfunction

  function automatic logic [N-1:0] cur_init(input bit sh);
    return sh ? s_init : l_init;
  endfunction

  task automatic drive_start(input bit sh, input logic st, input logic [N-1:0] v);
    if (sh) begin s_if.start = st; s_if.init_vec = v; end
    else    begin l_if.start = st; l_if.init_vec = v; end
  endtask

  // Called and returns at a negedge. Runs one request and checks it end to end.
  task automatic run_check(input bit sh, input logic [N-1:0] init, input bit spam,
                           input string tag, output int o_meet, output int o_per,
                           output logic [N-1:0] o_attr, output bit o_to);
    int meet, per, n_s1, max, lat, c0, c1, ct, cd;
    logic [N-1:0] attr;
    bit to, got, init_bad;
    max = sh ? MAX_S : MAX_L;
    ref_model(init, max, meet, per, attr, to, n_s1);
    c0 = sh ? s_s0_cnt : l_s0_cnt;
    c1 = sh ? s_s1_cnt : l_s1_cnt;
    ct = sh ? s_t_cnt  : l_t_cnt;
    cd = sh ? s_done_cnt : l_done_cnt;
    drive_start(sh, 1'b1, init);
    @(negedge clk);
    drive_start(sh, 1'b0, init);
    check({tag, "_load_rn"}, sh ? s_rn : l_rn, 1);
    check({tag, "_load_busy"}, sh ? s_if.busy : l_if.busy, 1);
    @(negedge clk);
    check({tag, "_first_step"}, sh ? {s_st0, s_st1, s_rn} : {l_st0, l_st1, l_rn}, 3'b110);
    lat = 2; got = 1'b0; init_bad = 1'b0;
    for (int c = 0; c < 4100 && !got; c++) begin
      if (cur_done(sh)) got = 1'b1;
      else begin
        if (cur_init(sh) !== init) init_bad = 1'b1;
        if (spam) drive_start(sh, 1'($urandom_range(0, 1)), N'($urandom));
        @(negedge clk);
        lat++;
      end
    end
    drive_start(sh, 1'b0, init);
    check({tag, "_done_seen"}, got, 1);
    check({tag, "_latency"}, lat, 2 + 2 * n_s1);
    check({tag, "_init_held"}, init_bad, 0);
    if (sh) begin
      o_meet = int'(s_if.meet_steps); o_per = int'(s_if.period);
      o_attr = s_if.attractor; o_to = s_if.timeout;
    end else begin
      o_meet = int'(l_if.meet_steps); o_per = int'(l_if.period);
      o_attr = l_if.attractor; o_to = l_if.timeout;
    end
    check({tag, "_meet"}, o_meet, meet);
    check({tag, "_period"}, o_per, per);
    check({tag, "_attr"}, o_attr, attr);
    check({tag, "_timeout"}, o_to, to);
    check({tag, "_init_state"}, cur_init(sh), init);
    @(negedge clk);
    check({tag, "_idle"}, sh ? {s_if.busy, s_if.done} : {l_if.busy, l_if.done}, 0);
    check({tag, "_hold_meet"}, sh ? s_if.meet_steps : l_if.meet_steps, meet);
    check({tag, "_n_start_s0"}, (sh ? s_s0_cnt : l_s0_cnt) - c0, meet);
    check({tag, "_n_start_s1"}, (sh ? s_s1_cnt : l_s1_cnt) - c1, n_s1);
    check({tag, "_n_tort_adv"}, (sh ? s_t_cnt : l_t_cnt) - ct, (meet + 1) / 2);
    check({tag, "_n_done"}, (sh ? s_done_cnt : l_done_cnt) - cd, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, {l_if.busy, l_if.done, l_if.timeout, l_rn, l_st0, l_st1}, 0);
    check({tag, "_res"}, {l_if.meet_steps, l_if.period, l_if.attractor, l_init}, 0);
    check({tag, "_short"}, {s_if.busy, s_if.done, s_if.timeout, s_rn, s_st0, s_st1,
                            s_if.meet_steps, s_if.period, s_if.attractor, s_init}, 0);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int m, p, cd;
    logic [N-1:0] a;
    bit t, found;

    rst = 1'b1;
    drive_start(1'b0, 1'b0, '0);
    drive_start(1'b1, 1'b0, '0);
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    net_sel = 0;
    run_check(1'b0, 8'hA5, 1'b0, "ident", m, p, a, t);
    check("ident_plan", {16'(m), 16'(p), a, 7'd0, t}, {16'd2, 16'd1, 8'hA5, 8'd0});

    net_sel = 1;
    run_check(1'b0, 8'h00, 1'b0, "toggle", m, p, a, t);
    check("toggle_plan", {16'(m), 16'(p), a}, {16'd4, 16'd2, 8'h00});

    net_sel = 2;
    cd = l_s0_cnt;
    run_check(1'b0, 8'h00, 1'b0, "incr", m, p, a, t);
    check("incr_plan", {16'(m), 16'(p), a}, {16'd16, 16'd8, 8'h00});
    check("incr_s0_pulses", l_s0_cnt - cd, 16);

    run_check(1'b1, 8'h00, 1'b0, "incr_to", m, p, a, t);
    check("incr_to_plan", {16'(m), 16'(p), 7'd0, t}, {16'd10, 16'd0, 8'd1});

    net_sel = 0;
    cd = l_done_cnt;
    drive_start(1'b0, 1'b1, 8'h5A);
    @(negedge clk);
    drive_start(1'b0, 1'b0, 8'h5A);
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      if (l_st1 && !l_st0) found = 1'b1;
      else @(negedge clk);
    end
    check("rst_pstep_reached", found, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("rst_mid");
    repeat (5) @(negedge clk);
    check("rst_no_done", l_done_cnt - cd, 0);
    run_check(1'b0, 8'h03, 1'b0, "rerun", m, p, a, t);
    check("rerun_plan", {16'(p), a}, {16'd1, 8'h03});

    net_sel = 1;
    run_check(1'b0, 8'h00, 1'b1, "spam", m, p, a, t);
    check("spam_plan", {16'(m), 16'(p), a}, {16'd4, 16'd2, 8'h00});

    net_sel = 3;
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 256; i++) lut[i] = N'($urandom);
      run_check(1'($urandom_range(0, 3) == 0), N'($urandom), 1'($urandom_range(0, 1)),
                $sformatf("rand%0d", r), m, p, a, t);
    end

    check("strobe_rules", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
